gprs_wb_ctrl: RTL and testbench
===============================

# gprs_wb_ctrl

Write-back controller that feeds the single write port of the general purpose register file. It merges ALU results and out-of-order load responses into one registered write per cycle, and buffers ALU results in a small FIFO when a load response collides with them. It keeps a load scoreboard and produces per-source hazard flags for the DEC stage read indices.

## Interface
Parameters:
- DEPTH, 2, ALU result FIFO entries; power of two, at least 2.

Ports:
- cpu_clk  in  1  CPU clock; all state updates on the rising edge.
- cpu_rst  in  1  reset, synchronous, active-high.
- alu_wb_valid  in  1  ALU result valid.
- alu_wb_ready  out  1  ALU result accepted when valid && ready.
- alu_wb_rd  in  5  ALU destination index.
- alu_wb_data  in  32  ALU result.
- ld_issue_valid  in  1  load issued; marks ld_issue_rd pending.
- ld_issue_rd  in  5  load destination index.
- ld_resp_valid  in  1  load data returned; always accepted, no ready.
- ld_resp_rd  in  5  load response destination.
- ld_resp_data  in  32  load response data.
- wr_valid  out  1  register file write valid.
- rd_wb  out  5  register file write index.
- wr_data  out  32  register file write data.
- rs1_dec, rs2_dec  in  5 each  DEC stage source indices.
- rs1_hazard, rs2_hazard  out  1 each  source not yet readable from the register file.
- rs1_fwd_valid, rs2_fwd_valid  out  1 each  present only with KRV_WB_FWD_EN.
- rs1_fwd_data, rs2_fwd_data  out  32 each  present only with KRV_WB_FWD_EN.

## Operation
- Write stage: wr_valid, rd_wb and wr_data are one register. Each cycle it loads at most one source, in priority order: ld_resp, then FIFO head, then a direct ALU result. If nothing is selected, wr_valid = 0.
- ALU path: an accepted result bypasses the FIFO only when the FIFO is empty and ld_resp_valid = 0. Otherwise it is pushed. ALU results leave in acceptance order.
- alu_wb_ready = !fifo_full && !cpu_rst, combinational from state. Push and pop in the same cycle are legal when full, but ready stays 0 while full.
- Index 0: a load response or ALU result targeting index 0 is consumed but never produces wr_valid. ld_issue to index 0 is ignored.
- Scoreboard pending[31:1]:
  - ld_issue_valid sets the bit; ld_resp_valid clears it.
  - If issue and response hit the same index in the same cycle, the set wins.
  - A response to a non-pending index is still written.
- Hazard: rsN_hazard = (rsN != 0) && (pending[rsN] || any valid FIFO entry with rd == rsN || (wr_valid && rd_wb == rsN)). The flag depends on registered state plus rsN only. Same-cycle ALU or load inputs are not included.
- WAW between an ALU result and a pending load to the same rd is prevented upstream by the hazard stall. It is not checked here.

## Timing
- Reset (cpu_rst high at an edge):
  - wr_valid = 0, rd_wb = 0, wr_data = 0.
  - FIFO empties and pending clears.
  - Hazard and fwd outputs are 0 when indices are 0.
  - Inputs are ignored and alu_wb_ready = 0 while reset is high.
  - Reset mid-operation discards buffered results and pending loads without writing them.
- Latency:
  - A direct ALU result or load response appears on wr_valid in the cycle after acceptance.
  - A buffered ALU result appears one cycle after it reaches the FIFO head with no load response present.
- The register file samples wr_valid at the next edge. A source becomes readable, with its hazard clear, in the cycle after wr_valid drops for that index.
- Sustained load responses starve the FIFO. The FIFO fills after DEPTH accepted ALU results, and alu_wb_ready then stays 0 until a free cycle.

## Configuration
- KRV_WB_FWD_EN defined:
  - rsN_fwd_valid = wr_valid && rd_wb == rsN && rsN != 0, and rsN_fwd_data = wr_data.
  - rsN_hazard ignores the write-stage match.
  - It still asserts for a pending load or a FIFO match, because a younger FIFO write to the same index makes forwarded data stale.
- Not defined: fwd ports are absent, and the write-stage match contributes to hazard as above.

## Test plan
- Reset, then ALU valid rd=5 data=0x1234 in cycle 0, FIFO empty -> cycle 1: wr_valid=1, rd_wb=5, wr_data=0x1234; rs1_dec=5 gives hazard=1 in cycle 1 (no fwd build), 0 in cycle 2.
- Same cycle: ld_resp rd=3 data=0xAAAA and ALU rd=4 data=0xBBBB -> cycle 1 writes x3; cycle 2 writes x4; no loss.
- ld_resp valid for 4 cycles with ALU valid every cycle, DEPTH=2 -> alu_wb_ready=0 after 2 accepts; ALU results drain in order once responses stop.
- ld_issue rd=7, then rs2_dec=7 -> rs2_hazard=1 until ld_resp rd=7 is written; issue and response to rd=7 in the same cycle -> pending stays 1.
- ALU rd=0 data=0xFFFF and ld_resp rd=0 -> wr_valid never asserts; rs1_dec=0 -> hazard=0.
- FIFO holding 2 entries and ld_issue rd=9 pending, then cpu_rst high 1 cycle -> no writes afterwards, rs1_dec=9 hazard=0, alu_wb_ready=1.

Source files
------------

// File: rtl/gprs_wb_ctrl.sv
// gprs_wb_ctrl: write-back controller for the single GPR write port.
// Merges load responses and ALU results into one registered write per cycle,
// buffers ALU results in a DEPTH-entry FIFO on collision with a load response,
// tracks pending loads and flags DEC-stage source hazards.
// Optional feature macro: KRV_WB_FWD_EN (adds write-stage forwarding ports).
//
// Handshake: an ALU result transfers on a rising edge where alu_wb_valid and
// alu_wb_ready are both 1; ready never depends on alu_wb_valid. Load responses
// and load issues have no back-pressure and are taken whenever valid.
module gprs_wb_ctrl #(
    parameter int DEPTH = 2
) (
    input  logic        cpu_clk,
    input  logic        cpu_rst,
    input  logic        alu_wb_valid,
    output logic        alu_wb_ready,
    input  logic [4:0]  alu_wb_rd,
    input  logic [31:0] alu_wb_data,
    input  logic        ld_issue_valid,
    input  logic [4:0]  ld_issue_rd,
    input  logic        ld_resp_valid,
    input  logic [4:0]  ld_resp_rd,
    input  logic [31:0] ld_resp_data,
    output logic        wr_valid,
    output logic [4:0]  rd_wb,
    output logic [31:0] wr_data,
    input  logic [4:0]  rs1_dec,
    input  logic [4:0]  rs2_dec,
`ifdef KRV_WB_FWD_EN
    output logic        rs1_fwd_valid,
    output logic [31:0] rs1_fwd_data,
    output logic        rs2_fwd_valid,
    output logic [31:0] rs2_fwd_data,
`endif
    output logic        rs1_hazard,
    output logic        rs2_hazard
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [4:0]       r_fifo_rd   [DEPTH];
    logic [31:0]      r_fifo_data [DEPTH];
    logic [DEPTH-1:0] r_fvld;
    logic [AW-1:0]    r_rptr;
    logic [AW-1:0]    r_wptr;
    logic [AW:0]      r_count;
    logic [31:0]      r_pending;
    logic             r_wr_valid;
    logic [4:0]       r_rd_wb;
    logic [31:0]      r_wr_data;

    logic        w_empty;
    logic        w_full;
    logic        w_alu_acc;
    logic        w_push;
    logic        w_pop;
    logic [31:0] w_pending_nxt;
    logic        w_fifo_hit1;
    logic        w_fifo_hit2;
    logic        w_wb_hit1;
    logic        w_wb_hit2;

    assign w_empty      = (r_count == '0);
    assign w_full       = (r_count == FULL_CNT);
    assign alu_wb_ready = !w_full && !cpu_rst;
    assign w_alu_acc    = alu_wb_valid && alu_wb_ready;
    // The FIFO head drains only in cycles free of a load response.
    assign w_pop        = !ld_resp_valid && !w_empty;
    // Bypass only when nothing older is waiting and no load claims the port.
    assign w_push       = w_alu_acc && !(w_empty && !ld_resp_valid);

    assign wr_valid = r_wr_valid;
    assign rd_wb    = r_rd_wb;
    assign wr_data  = r_wr_data;

    // Next scoreboard value: clear on response first so a same-index issue wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (ld_resp_valid) w_pending_nxt[ld_resp_rd] = 1'b0;
        if (ld_issue_valid && ld_issue_rd != 5'd0) w_pending_nxt[ld_issue_rd] = 1'b1;
        w_pending_nxt[0] = 1'b0;
    end

    // Source matches against buffered ALU results and the write stage.
    always_comb begin
        w_fifo_hit1 = 1'b0;
        w_fifo_hit2 = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (r_fvld[i] && r_fifo_rd[i] == rs1_dec) w_fifo_hit1 = 1'b1;
            if (r_fvld[i] && r_fifo_rd[i] == rs2_dec) w_fifo_hit2 = 1'b1;
        end
        w_wb_hit1 = r_wr_valid && (r_rd_wb == rs1_dec);
        w_wb_hit2 = r_wr_valid && (r_rd_wb == rs2_dec);
    end

`ifdef KRV_WB_FWD_EN
    // Write-stage data is forwarded, so only pending loads and FIFO entries stall.
    assign rs1_hazard    = (rs1_dec != 5'd0) && (r_pending[rs1_dec] || w_fifo_hit1);
    assign rs2_hazard    = (rs2_dec != 5'd0) && (r_pending[rs2_dec] || w_fifo_hit2);
    assign rs1_fwd_valid = w_wb_hit1 && (rs1_dec != 5'd0);
    assign rs2_fwd_valid = w_wb_hit2 && (rs2_dec != 5'd0);
    assign rs1_fwd_data  = r_wr_data;
    assign rs2_fwd_data  = r_wr_data;
`else
    assign rs1_hazard = (rs1_dec != 5'd0) && (r_pending[rs1_dec] || w_fifo_hit1 || w_wb_hit1);
    assign rs2_hazard = (rs2_dec != 5'd0) && (r_pending[rs2_dec] || w_fifo_hit2 || w_wb_hit2);
`endif

    // Load scoreboard register.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) r_pending <= '0;
        else         r_pending <= w_pending_nxt;
    end

    // ALU result FIFO: storage, per-entry valid bits, pointers and occupancy.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_fvld  <= '0;
            r_rptr  <= '0;
            r_wptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_fifo_rd[r_wptr]   <= alu_wb_rd;
                r_fifo_data[r_wptr] <= alu_wb_data;
                r_fvld[r_wptr]      <= 1'b1;
                r_wptr              <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_fvld[r_rptr] <= 1'b0;
                r_rptr         <= r_rptr + 1'b1;
            end
            if (w_push && !w_pop)      r_count <= r_count + 1'b1;
            else if (!w_push && w_pop) r_count <= r_count - 1'b1;
        end
    end

    // Write stage: load response, then FIFO head, then direct ALU result.
    always_ff @(posedge cpu_clk) begin
        if (cpu_rst) begin
            r_wr_valid <= 1'b0;
            r_rd_wb    <= 5'd0;
            r_wr_data  <= 32'd0;
        end else if (ld_resp_valid) begin
            r_wr_valid <= (ld_resp_rd != 5'd0);
            r_rd_wb    <= ld_resp_rd;
            r_wr_data  <= ld_resp_data;
        end else if (!w_empty) begin
            r_wr_valid <= (r_fifo_rd[r_rptr] != 5'd0);
            r_rd_wb    <= r_fifo_rd[r_rptr];
            r_wr_data  <= r_fifo_data[r_rptr];
        end else if (w_alu_acc) begin
            r_wr_valid <= (alu_wb_rd != 5'd0);
            r_rd_wb    <= alu_wb_rd;
            r_wr_data  <= alu_wb_data;
        end else begin
            r_wr_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_gprs_wb_ctrl.sv
// Testbench for gprs_wb_ctrl: directed scenarios plus random traffic,
// checked against a queue-based reference model and a write scoreboard.
module tb_gprs_wb_ctrl;
  localparam int DEPTH = 2;

  logic        cpu_clk = 1'b0;
  logic        cpu_rst;
  logic        alu_wb_valid;
  logic        alu_wb_ready;
  logic [4:0]  alu_wb_rd;
  logic [31:0] alu_wb_data;
  logic        ld_issue_valid;
  logic [4:0]  ld_issue_rd;
  logic        ld_resp_valid;
  logic [4:0]  ld_resp_rd;
  logic [31:0] ld_resp_data;
  logic        wr_valid;
  logic [4:0]  rd_wb;
  logic [31:0] wr_data;
  logic [4:0]  rs1_dec;
  logic [4:0]  rs2_dec;
  logic        rs1_hazard;
  logic        rs2_hazard;
`ifdef KRV_WB_FWD_EN
  logic        rs1_fwd_valid;
  logic [31:0] rs1_fwd_data;
  logic        rs2_fwd_valid;
  logic [31:0] rs2_fwd_data;
`endif

  gprs_wb_ctrl #(.DEPTH(DEPTH)) dut (
    .cpu_clk(cpu_clk), .cpu_rst(cpu_rst),
    .alu_wb_valid(alu_wb_valid), .alu_wb_ready(alu_wb_ready),
    .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .ld_issue_valid(ld_issue_valid), .ld_issue_rd(ld_issue_rd),
    .ld_resp_valid(ld_resp_valid), .ld_resp_rd(ld_resp_rd), .ld_resp_data(ld_resp_data),
    .wr_valid(wr_valid), .rd_wb(rd_wb), .wr_data(wr_data),
    .rs1_dec(rs1_dec), .rs2_dec(rs2_dec),
`ifdef KRV_WB_FWD_EN
    .rs1_fwd_valid(rs1_fwd_valid), .rs1_fwd_data(rs1_fwd_data),
    .rs2_fwd_valid(rs2_fwd_valid), .rs2_fwd_data(rs2_fwd_data),
`endif
    .rs1_hazard(rs1_hazard), .rs2_hazard(rs2_hazard)
  );

  // clock / reset
  always #5 cpu_clk = ~cpu_clk;

  int total = 0;
  int bad   = 0;

  // scoreboard: expected register-file writes {rd, data} in order
  logic [36:0] exp_q[$];

  // reference model state
  logic [36:0] m_q[$];      // ALU results waiting behind load responses
  logic        m_pend[32];  // loads issued and not yet answered
  logic        m_wv;        // write stage holds a real write
  logic [4:0]  m_wrd;
  logic [31:0] m_wdata;
  logic        m_after_rst;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic m_hazard(input logic [4:0] rs);
    logic h;
    h = m_pend[rs];
    foreach (m_q[i]) if (m_q[i][36:32] == rs) h = 1'b1;
`ifndef KRV_WB_FWD_EN
    if (m_wv && m_wrd == rs) h = 1'b1;
`endif
    return (rs != 5'd0) && h;
  endfunction

  // monitor: every write the DUT presents must match the scoreboard head
  initial begin
    forever begin
      @(negedge cpu_clk);
      if (wr_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_write: got rd=%0d data=%0h expected none at %0t", rd_wb, wr_data, $time);
        end else begin
          logic [36:0] e;
          e = exp_q.pop_front();
          chk("wr_rd", {27'd0, rd_wb}, {27'd0, e[36:32]});
          chk("wr_data", wr_data, e[31:0]);
        end
      end
    end
  end

  // driver: apply one cycle of inputs, check combinational outputs, advance model
  task automatic step(input logic rst, input logic av, input logic [4:0] ard, input logic [31:0] adat,
                      input logic iv, input logic [4:0] ird,
                      input logic rv, input logic [4:0] rrd, input logic [31:0] rdat,
                      input logic [4:0] s1, input logic [4:0] s2);
    logic m_ready, acc, sel;
    logic [36:0] w;
    @(negedge cpu_clk);
    cpu_rst = rst; alu_wb_valid = av; alu_wb_rd = ard; alu_wb_data = adat;
    ld_issue_valid = iv; ld_issue_rd = ird;
    ld_resp_valid = rv; ld_resp_rd = rrd; ld_resp_data = rdat;
    rs1_dec = s1; rs2_dec = s2;
    #1;
    if (m_after_rst) begin
      chk("rst_rd_wb", {27'd0, rd_wb}, 32'd0);
      chk("rst_wr_data", wr_data, 32'd0);
      m_after_rst = 1'b0;
    end
    m_ready = !rst && (m_q.size() < DEPTH);
    chk("alu_ready", {31'd0, alu_wb_ready}, {31'd0, m_ready});
    chk("rs1_hazard", {31'd0, rs1_hazard}, {31'd0, m_hazard(s1)});
    chk("rs2_hazard", {31'd0, rs2_hazard}, {31'd0, m_hazard(s2)});
`ifdef KRV_WB_FWD_EN
    chk("rs1_fwd_valid", {31'd0, rs1_fwd_valid}, {31'd0, m_wv && m_wrd == s1 && s1 != 0});
    if (m_wv && m_wrd == s1 && s1 != 0) chk("rs1_fwd_data", rs1_fwd_data, m_wdata);
`endif
    if (rst) begin
      m_q.delete();
      foreach (m_pend[i]) m_pend[i] = 1'b0;
      m_wv = 1'b0;
      m_after_rst = 1'b1;
    end else begin
      acc = av && m_ready;
      sel = 1'b1;
      if (rv) w = {rrd, rdat};
      else if (m_q.size() > 0) w = m_q.pop_front();
      else if (acc) begin w = {ard, adat}; acc = 1'b0; end
      else sel = 1'b0;
      if (acc) m_q.push_back({ard, adat});
      m_wv = sel && (w[36:32] != 5'd0);
      m_wrd = w[36:32];
      m_wdata = w[31:0];
      if (m_wv) exp_q.push_back(w);
      if (rv) m_pend[rrd] = 1'b0;
      if (iv && ird != 5'd0) m_pend[ird] = 1'b1;
      m_pend[0] = 1'b0;
    end
  endtask

  task automatic idle(input logic [4:0] s1, input logic [4:0] s2);
    step(0, 0, 0, 0, 0, 0, 0, 0, 0, s1, s2);
  endtask

  initial begin
    cpu_rst = 1'b1; alu_wb_valid = 0; alu_wb_rd = 0; alu_wb_data = 0;
    ld_issue_valid = 0; ld_issue_rd = 0; ld_resp_valid = 0; ld_resp_rd = 0; ld_resp_data = 0;
    rs1_dec = 0; rs2_dec = 0;
    m_wv = 0; m_wrd = 0; m_wdata = 0; m_after_rst = 0;
    foreach (m_pend[i]) m_pend[i] = 1'b0;

    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 1, 3, 32'h55, 1, 4, 1, 6, 32'h66, 0, 0);  // inputs ignored in reset

    // direct ALU write and write-stage hazard
    step(0, 1, 5, 32'h1234, 0, 0, 0, 0, 0, 5, 0);
    idle(5, 0);
    idle(5, 0);

    // load response and ALU result collide
    step(0, 1, 4, 32'hBBBB, 0, 0, 1, 3, 32'hAAAA, 3, 4);
    idle(3, 4);
    idle(3, 4);
    idle(4, 3);

    // sustained load responses fill the FIFO
    for (int i = 0; i < 4; i++)
      step(0, 1, 5'(10 + i), 32'hC000 + i, 0, 0, 1, 5'(20 + i), 32'hD000 + i, 5'(10 + i), 11);
    for (int i = 0; i < 3; i++) idle(10, 11);

    // pending load hazard, same-cycle issue and response
    step(0, 0, 0, 0, 1, 7, 0, 0, 0, 0, 7);
    idle(0, 7);
    step(0, 0, 0, 0, 1, 7, 1, 7, 32'h7777, 0, 7);
    idle(0, 7);
    step(0, 0, 0, 0, 0, 0, 1, 7, 32'h7070, 0, 7);
    idle(0, 7);
    idle(0, 7);

    // index 0 never writes
    step(0, 1, 0, 32'hFFFF, 0, 0, 1, 0, 32'hFFFF, 0, 0);
    idle(0, 0);
    idle(0, 0);

    // reset discards buffered results and pending loads
    step(0, 1, 12, 32'h1, 1, 9, 1, 2, 32'h2, 12, 9);
    step(0, 1, 13, 32'h3, 0, 0, 1, 1, 32'h4, 12, 9);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 9, 12);
    idle(9, 12);
    idle(9, 13);

    // random traffic
    for (int i = 0; i < 400; i++) begin
      step(($urandom_range(0, 99) == 0),
           ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 15)), $urandom,
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)),
           ($urandom_range(0, 9) < 3), 5'($urandom_range(0, 15)), $urandom,
           5'($urandom_range(0, 15)), 5'($urandom_range(0, 15)));
    end
    for (int i = 0; i < DEPTH + 4; i++) idle(0, 0);

    @(negedge cpu_clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
